// File: rtl/water_flow_if.sv
// water_flow_if: level sample, direction and fault flag between the valve controller side and the flow monitor
interface water_flow_if;
  logic [9:0] water_level_sensor;
  logic       mode;
  logic       error_flag;
  modport master(output water_level_sensor, mode, input error_flag);
  modport slave(input water_level_sensor, mode, output error_flag);
endinterface

// File: rtl/water_flow_monitor.sv
// water_flow_monitor: sticky fault when the water level fails to move in the commanded direction fast enough
module water_flow_monitor #(
  parameter int THRESHOLD  = 10,
  parameter int TIME_LIMIT = 10
) (
  input logic         clk,
  input logic         reset,
  water_flow_if.slave bus
);
  localparam int CW = $clog2(TIME_LIMIT + 1);
  typedef enum logic [1:0] {PRIME, MONITOR, ERROR} state_t;
  state_t          state;
  logic [9:0]      prev_level;
  logic [CW-1:0]   stall_cnt;
  logic            last_mode;
  logic            error_flag;
  logic [10:0]     lvl, prv, th;
  logic            progress;
  assign bus.error_flag = error_flag;
  // Per-sample progress test in 11 bits so neither sum can wrap at the rails
  always_comb begin
    lvl      = {1'b0, bus.water_level_sensor};
    prv      = {1'b0, prev_level};
    th       = 11'(THRESHOLD);
    progress = bus.mode ? (lvl >= prv + th) : (lvl + th <= prv);
  end
  // Prime / monitor / latched-error supervisor; error only exits through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PRIME;
      stall_cnt  <= '0;
      prev_level <= '0;
      last_mode  <= bus.mode;
      error_flag <= 1'b0;
    end else begin
      last_mode <= bus.mode;
      if (state == PRIME) begin
        prev_level <= bus.water_level_sensor;
        stall_cnt  <= '0;
        state      <= MONITOR;
      end else if (state == MONITOR) begin
        prev_level <= bus.water_level_sensor;
        if (bus.mode != last_mode) begin
          state     <= PRIME;
          stall_cnt <= '0;
        end else if (progress) begin
          stall_cnt <= '0;
        end else if (stall_cnt == CW'(TIME_LIMIT - 1)) begin
          stall_cnt  <= stall_cnt + 1'b1;
          state      <= ERROR;
          error_flag <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_water_flow_monitor.sv
// tb_water_flow_monitor: directed vector table plus hand sequences for mode toggles and reset
module tb_water_flow_monitor;
  typedef struct {
    int         grp;
    logic       rst;
    logic       md;
    logic [9:0] lvl;
    logic       exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  water_flow_if bus();
  water_flow_monitor dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void push(int g, logic r, logic m, logic [9:0] l, logic e);
    vec_t v;
    v.grp = g; v.rst = r; v.md = m; v.lvl = l; v.exp = e;
    vecs.push_back(v);
  endfunction
  task automatic apply(input logic r, input logic m, input logic [9:0] l);
    reset = r;
    bus.mode = m;
    bus.water_level_sensor = l;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic exp);
    n_cmp++;
    if (bus.error_flag !== exp) begin
      n_bad++;
      $display("FAIL %s: error_flag=%0b expected %0b", nm, bus.error_flag, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.mode = 1'b1;
    bus.water_level_sensor = '0;
    // fill normal then stall
    push(1, 1, 1, 10'd50, 0); push(1, 0, 1, 10'd50, 0);
    for (int i = 1; i <= 5; i++) push(1, 0, 1, 10'(50 + 20 * i), 0);
    for (int i = 1; i <= 10; i++) push(2, 0, 1, 10'd150, i == 10);
    for (int i = 1; i <= 5; i++) push(2, 0, 1, 10'd150, 1);
    // drain normal then stall
    push(3, 1, 0, 10'd200, 0); push(3, 0, 0, 10'd200, 0);
    for (int i = 1; i <= 5; i++) push(3, 0, 0, 10'(200 - 20 * i), 0);
    for (int i = 1; i <= 10; i++) push(3, 0, 0, 10'd100, i == 10);
    // slow fill and slow drain
    push(4, 1, 1, 10'd50, 0); push(4, 0, 1, 10'd50, 0);
    for (int i = 1; i <= 10; i++) push(4, 0, 1, 10'(50 + 5 * i), i == 10);
    push(4, 1, 0, 10'd200, 0); push(4, 0, 0, 10'd200, 0);
    for (int i = 1; i <= 10; i++) push(4, 0, 0, 10'(200 - 5 * i), i == 10);
    // exactly THRESHOLD is progress, one short is not
    push(5, 1, 1, 10'd100, 0); push(5, 0, 1, 10'd100, 0);
    for (int i = 1; i <= 20; i++) push(5, 0, 1, 10'(100 + 10 * i), 0);
    push(5, 1, 0, 10'd600, 0); push(5, 0, 0, 10'd600, 0);
    for (int i = 1; i <= 20; i++) push(5, 0, 0, 10'(600 - 10 * i), 0);
    push(5, 1, 1, 10'd100, 0); push(5, 0, 1, 10'd100, 0);
    for (int i = 1; i <= 10; i++) push(5, 0, 1, 10'(100 + 9 * i), i == 10);
    push(5, 1, 0, 10'd300, 0); push(5, 0, 0, 10'd300, 0);
    for (int i = 1; i <= 10; i++) push(5, 0, 0, 10'(300 - 9 * i), i == 10);
    // saturation at the rails
    push(6, 1, 1, 10'd1023, 0); push(6, 0, 1, 10'd1023, 0);
    for (int i = 1; i <= 10; i++) push(6, 0, 1, 10'd1023, i == 10);
    push(6, 1, 0, 10'd0, 0); push(6, 0, 0, 10'd0, 0);
    for (int i = 1; i <= 10; i++) push(6, 0, 0, 10'd0, i == 10);
    // wrong direction while filling, and a plain fast drain
    push(7, 1, 1, 10'd500, 0); push(7, 0, 1, 10'd500, 0);
    for (int i = 1; i <= 10; i++) push(7, 0, 1, 10'(500 - 30 * i), i == 10);
    push(7, 1, 0, 10'd800, 0); push(7, 0, 0, 10'd800, 0);
    for (int i = 1; i <= 10; i++) push(7, 0, 0, 10'(800 - 20 * i), 0);
    foreach (vecs[k]) begin
      apply(vecs[k].rst, vecs[k].md, vecs[k].lvl);
      n_cmp++;
      if (bus.error_flag !== vecs[k].exp) begin
        n_bad++;
        $display("FAIL vec grp%0d idx%0d lvl=%0d: error_flag=%0b expected %0b",
                 vecs[k].grp, k, vecs[k].lvl, bus.error_flag, vecs[k].exp);
      end
    end
    // mode toggle restarts the stall count
    apply(1, 1, 10'd500); check("toggle_reset", 0);
    apply(0, 1, 10'd500); check("toggle_prime", 0);
    for (int i = 1; i <= 8; i++) begin apply(0, 1, 10'd500); check("toggle_stall_a", 0); end
    apply(0, 0, 10'd500); check("toggle_edge", 0);
    apply(0, 0, 10'd500); check("toggle_reprime", 0);
    for (int i = 1; i <= 8; i++) begin apply(0, 0, 10'd500); check("toggle_stall_b", 0); end
    apply(0, 0, 10'd500); check("toggle_stall_9", 0);
    apply(0, 0, 10'd500); check("toggle_stall_10", 1);
    // ERROR ignores mode and sensor; reset clears it in one edge
    apply(0, 1, 10'd500); check("error_mode_toggle", 1);
    apply(0, 1, 10'd900); check("error_level_jump", 1);
    apply(1, 1, 10'd900); check("error_reset", 0);
    apply(0, 1, 10'd900); check("post_reset_prime", 0);
    // reset mid-count discards accumulated stalls
    for (int i = 1; i <= 5; i++) begin apply(0, 1, 10'd900); check("mid_stall", 0); end
    apply(1, 1, 10'd900); check("mid_reset", 0);
    apply(0, 1, 10'd900); check("mid_prime", 0);
    for (int i = 1; i <= 9; i++) begin apply(0, 1, 10'd900); check("mid_restall", 0); end
    apply(0, 1, 10'd900); check("mid_restall_10", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
